stack_arbiter: RTL and testbench

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_pkg.sv | 17 +
 rtl/stack_mem.sv | 28 ++
 rtl/stack_arbiter.sv | 140 ++++++++++++++
 tb/tb_stack_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared constants, op encoding and FSM states for the arbitrated stack
package stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 1024;
    localparam int STACK_AW    = $clog2(STACK_DEPTH);

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - single-port stack RAM, synchronous write, registered read
module stack_mem
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    // No reset: contents survive a reset of the controller.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-requester round-robin front end for a push/pop stack
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     op0,
    input  logic                     op1,
    input  logic [WIDTH-1:0]         wdata0,
    input  logic [WIDTH-1:0]         wdata1,
    output logic                     ack0,
    output logic                     ack1,
    output logic [WIDTH-1:0]         rdata,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);

    state_t           r_state;
    logic             r_winner;
    logic             r_last;
    logic             r_op;
    logic [WIDTH-1:0] r_wdata;
    logic [DW-1:0]    r_depth;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_err;

    logic             w_full;
    logic             w_empty;
    logic             w_any_req;
    logic             w_grant;
    logic             w_sel_op;
    logic [WIDTH-1:0] w_sel_wdata;
    logic             w_illegal;
    logic             w_mem_we;
    logic             w_mem_re;
    logic [AW-1:0]    w_addr_m1;
    logic [AW-1:0]    w_mem_addr;
    logic [WIDTH-1:0] w_mem_rdata;

    assign w_full    = (r_depth == DEPTH_C);
    assign w_empty   = (r_depth == '0);
    assign w_any_req = req0 | req1;

    // On a tie the requester that was not served last wins; a lone request always wins.
    assign w_grant     = (req0 & req1) ? ~r_last : req1;
    assign w_sel_op    = w_grant ? op1 : op0;
    assign w_sel_wdata = w_grant ? wdata1 : wdata0;

    assign w_illegal  = (r_op == OP_PUSH) ? w_full : w_empty;
    assign w_mem_we   = (r_state == ST_EXEC) && (r_op == OP_PUSH) && !w_full;
    assign w_mem_re   = (r_state == ST_EXEC) && (r_op == OP_POP) && !w_empty;
    // Low bits minus one is exact for depth 1..DEPTH, including the full case.
    assign w_addr_m1  = r_depth[AW-1:0] - AW'(1);
    assign w_mem_addr = (r_op == OP_PUSH) ? r_depth[AW-1:0] : w_addr_m1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_winner <= 1'b0;
            r_last   <= 1'b1;
            r_op     <= OP_POP;
            r_wdata  <= '0;
            r_depth  <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_winner <= w_grant;
                        r_last   <= w_grant;
                        r_op     <= w_sel_op;
                        r_wdata  <= w_sel_wdata;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_err  <= w_illegal;
                    r_ack0 <= ~r_winner;
                    r_ack1 <= r_winner;
                    if (!w_illegal) begin
                        if (r_op == OP_PUSH) begin
                            r_depth <= r_depth + DW'(1);
                        end else begin
                            r_depth <= r_depth - DW'(1);
                        end
                    end
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign ack0  = r_ack0;
    assign ack1  = r_ack1;
    assign err   = r_err;
    assign rdata = w_mem_rdata;
    assign depth = r_depth;
    assign full  = w_full;
    assign empty = w_empty;

endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - directed self-checking bench for stack_arbiter
module tb_stack_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, op0, op1;
    logic [7:0]  wdata0, wdata1;
    logic        ack0, ack1, err, full, empty;
    logic [7:0]  rdata;
    logic [10:0] depth;

    int n_checks = 0;
    int n_fail   = 0;

    int q_port[$];
    int q_cyc[$];
    int n_both;

    stack_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .op0    (op0),
        .op1    (op1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .ack0   (ack0),
        .ack1   (ack1),
        .rdata  (rdata),
        .err    (err),
        .depth  (depth),
        .full   (full),
        .empty  (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int port_at(input int i);
        return (i < q_port.size()) ? q_port[i] : -1;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < q_cyc.size()) ? q_cyc[i] : -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One request; ack expected on the third falling edge after raising req from IDLE.
    task automatic op_single(input int who, input logic op, input logic [7:0] d,
                             output logic [7:0] rd, output logic er);
        int lat;
        bit got;
        @(posedge clk);
        #1;
        if (who == 0) begin
            req0 = 1'b1; op0 = op; wdata0 = d;
        end else begin
            req1 = 1'b1; op1 = op; wdata1 = d;
        end
        got = 1'b0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (ack0 || ack1) begin
                got = 1'b1;
                rd  = rdata;
                er  = err;
                check("ack_port", {63'd0, ack1}, 64'(who));
                check("ack_both", {63'd0, ack0 & ack1}, 64'd0);
            end
        end
        check("ack_latency", 64'(lat), 64'd3);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Both requesters push; each drops req on the ack edge and re-raises a cycle later.
    task automatic dual(input int dly1, input int reps0, input int reps1,
                        input logic [7:0] base0, input logic [7:0] base1);
        int n0, n1;
        bit pend0, pend1, s0, s1;
        q_port.delete();
        q_cyc.delete();
        n_both = 0;
        n0 = 0; n1 = 0; pend0 = 0; pend1 = 0;
        @(posedge clk);
        #1;
        op0 = 1'b1; op1 = 1'b1;
        wdata0 = base0; wdata1 = base1;
        req0 = (reps0 > 0);
        req1 = (reps1 > 0) && (dly1 == 0);
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            s0 = ack0;
            s1 = ack1;
            if (s0 && s1) n_both++;
            if (s0) begin q_port.push_back(0); q_cyc.push_back(n); end
            if (s1) begin q_port.push_back(1); q_cyc.push_back(n); end
            if (!s0 && !s1 && err) n_both++;
            @(posedge clk);
            #1;
            if (pend0) begin req0 = 1'b1; pend0 = 0; end
            if (pend1) begin req1 = 1'b1; pend1 = 0; end
            if (dly1 > 0 && n == dly1 && reps1 > 0) req1 = 1'b1;
            if (s0) begin
                req0 = 1'b0; n0++; wdata0 = wdata0 + 8'd1;
                if (n0 < reps0) pend0 = 1;
            end
            if (s1) begin
                req1 = 1'b0; n1++; wdata1 = wdata1 + 8'd1;
                if (n1 < reps1) pend1 = 1;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;
        int         nerr;
        logic [7:0] exp_pop [4];

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
        wdata0 = '0; wdata1 = '0;

        @(negedge clk);
        check("rst_depth", 64'(depth), 64'd0);
        check("rst_empty", {63'd0, empty}, 64'd1);
        check("rst_full",  {63'd0, full}, 64'd0);
        check("rst_acks",  {62'd0, ack0, ack1}, 64'd0);
        check("rst_err",   {63'd0, err}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // LIFO order on requester 0
        op_single(0, 1'b1, 8'h11, rd, er); check("push11_err", {63'd0, er}, 64'd0);
        op_single(0, 1'b1, 8'h22, rd, er); check("push22_err", {63'd0, er}, 64'd0);
        op_single(0, 1'b1, 8'h33, rd, er); check("push33_err", {63'd0, er}, 64'd0);
        check("depth3", 64'(depth), 64'd3);
        op_single(0, 1'b0, 8'h00, rd, er);
        check("pop1_data", 64'(rd), 64'h33); check("pop1_err", {63'd0, er}, 64'd0);
        op_single(0, 1'b0, 8'h00, rd, er);
        check("pop2_data", 64'(rd), 64'h22); check("pop2_err", {63'd0, er}, 64'd0);
        op_single(0, 1'b0, 8'h00, rd, er);
        check("pop3_data", 64'(rd), 64'h11); check("pop3_err", {63'd0, er}, 64'd0);
        check("depth0", 64'(depth), 64'd0);
        check("empty_after_pops", {63'd0, empty}, 64'd1);

        // Underflow on requester 1
        op_single(1, 1'b0, 8'h00, rd, er);
        check("underflow_err", {63'd0, er}, 64'd1);
        check("underflow_depth", 64'(depth), 64'd0);
        op_single(1, 1'b1, 8'h5A, rd, er);
        check("push5a_err", {63'd0, er}, 64'd0);
        check("push5a_depth", 64'(depth), 64'd1);
        check("err_idle", {63'd0, err}, 64'd0);
        op_single(0, 1'b0, 8'h00, rd, er);
        check("pop5a_data", 64'(rd), 64'h5A);

        // Fill to DEPTH, overflow, then pop the top entry
        nerr = 0;
        for (int i = 0; i < 1024; i++) begin
            op_single(0, 1'b1, 8'(i), rd, er);
            if (er) nerr++;
        end
        check("fill_errs", 64'(nerr), 64'd0);
        check("fill_full", {63'd0, full}, 64'd1);
        check("fill_depth", 64'(depth), 64'd1024);
        check("fill_empty", {63'd0, empty}, 64'd0);
        op_single(1, 1'b1, 8'hEE, rd, er);
        check("overflow_err", {63'd0, er}, 64'd1);
        check("overflow_depth", 64'(depth), 64'd1024);
        op_single(0, 1'b0, 8'h00, rd, er);
        check("top_pop_data", 64'(rd), 64'hFF);
        check("top_pop_err", {63'd0, er}, 64'd0);
        check("top_pop_full", {63'd0, full}, 64'd0);
        check("top_pop_depth", 64'(depth), 64'd1023);

        // Contention: grants alternate 0,1,0,1 at a 3-cycle cadence
        do_reset();
        dual(0, 2, 2, 8'hA0, 8'hB0);
        check("rr_count", 64'(q_port.size()), 64'd4);
        check("rr_both", 64'(n_both), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check("rr_port", 64'(port_at(k)), 64'(k % 2));
            check("rr_cycle", 64'(cyc_at(k)), 64'(3 * (k + 1)));
        end
        check("rr_depth", 64'(depth), 64'd4);
        exp_pop[0] = 8'hB1; exp_pop[1] = 8'hA1; exp_pop[2] = 8'hB0; exp_pop[3] = 8'hA0;
        for (int k = 0; k < 4; k++) begin
            op_single(0, 1'b0, 8'h00, rd, er);
            check("rr_pop_data", 64'(rd), 64'(exp_pop[k]));
        end

        // Tie after requester 0 was served last: requester 1 wins first
        dual(0, 1, 1, 8'hC0, 8'hD0);
        check("tie_count", 64'(q_port.size()), 64'd2);
        check("tie_first", 64'(port_at(0)), 64'd1);
        check("tie_second", 64'(port_at(1)), 64'd0);
        check("tie_cycle2", 64'(cyc_at(1)), 64'd6);

        // Requester 1 arrives during requester 0's EXEC and waits for the next IDLE
        dual(1, 1, 1, 8'hE0, 8'hF0);
        check("late_count", 64'(q_port.size()), 64'd2);
        check("late_port0", 64'(port_at(0)), 64'd0);
        check("late_cyc0", 64'(cyc_at(0)), 64'd3);
        check("late_port1", 64'(port_at(1)), 64'd1);
        check("late_cyc1", 64'(cyc_at(1)), 64'd6);
        check("late_both", 64'(n_both), 64'd0);
        op_single(0, 1'b0, 8'h00, rd, er);
        check("late_pop_data", 64'(rd), 64'hF0);

        // Reset during EXEC of a push at depth 5
        do_reset();
        for (int i = 1; i <= 5; i++) op_single(0, 1'b1, 8'(i), rd, er);
        check("pre_rst_depth", 64'(depth), 64'd5);
        @(posedge clk);
        #1;
        req0 = 1'b1; op0 = 1'b1; wdata0 = 8'h66;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_depth", 64'(depth), 64'd0);
        check("midrst_empty", {63'd0, empty}, 64'd1);
        check("midrst_ack", {62'd0, ack0, ack1}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_ack_later", {62'd0, ack0, ack1}, 64'd0);
        check("midrst_depth_later", 64'(depth), 64'd0);
        req0 = 1'b0;
        rst = 1'b0;
        op_single(0, 1'b1, 8'h77, rd, er);
        check("post_rst_push_err", {63'd0, er}, 64'd0);
        op_single(0, 1'b0, 8'h00, rd, er);
        check("post_rst_pop_data", 64'(rd), 64'h77);
        check("post_rst_depth", 64'(depth), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
